btn_debouncer: RTL and testbench
================================

# btn_debouncer

Conditions the raw push-button inputs of the board before they reach the ALU operand/opcode load registers. Each button channel is synchronized to `CLK100MHZ`, debounced by a stability counter, and turned into a clean level plus a single-cycle press pulse. The pulses drive the load enables for operand A, operand B and the opcode register, so one physical press loads exactly once.

## Interface
- `N_BTN`, default 3: number of independent button channels (bit 0 = btnL, 1 = btnC, 2 = btnR in the top).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each channel counter.

- `CLK100MHZ`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `i_btn`  input  N_BTN  raw, asynchronous, bouncing button levels.
- `o_level`  output  N_BTN  debounced button level.
- `o_pulse`  output  N_BTN  one-cycle high pulse on each accepted press (0→1 of `o_level`).

## Operation
- Per channel, fully independent; no interaction between channels.
- 2-FF synchronizer: `i_btn` → `sync1` → `sync2` (`s`). Only `s` is used downstream.
- Per-channel FSM, 4 states:
  - `STABLE_LOW`: `o_level`=0. If `s`=1: go `ARM_HIGH`, `cnt`=1.
  - `ARM_HIGH`: if `s`=0: back to `STABLE_LOW`, `cnt`=0 (bounce rejected). If `s`=1 and `cnt`=DEBOUNCE_CYCLES-1: go `STABLE_HIGH`, `o_level`←1, `o_pulse`←1, `cnt`=0. Else `cnt`++.
  - `STABLE_HIGH`: `o_level`=1. If `s`=0: go `ARM_LOW`, `cnt`=1.
  - `ARM_LOW`: mirror of `ARM_HIGH`; on acceptance `o_level`←0, no pulse (release emits nothing).
- `o_pulse` is registered, high for exactly one cycle per accepted press; it clears the next cycle regardless of input.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Reset (any time, including mid-ARM): sync FFs 0, state `STABLE_LOW`, `cnt` 0, `o_level` 0, `o_pulse` 0. Pending counts discarded.
- Button held through reset release: treated as a fresh press; pulse after full latency.
- Simultaneous presses on several channels: each pulses on its own schedule; identical inputs give same-cycle pulses.

## Timing
- Reset values: `o_level`=0, `o_pulse`=0 for all channels.
- `i_btn` rises cleanly before edge k: `sync1`=1 after edge k, `s`=1 after edge k+1, FSM enters `ARM_HIGH` at edge k+2; `o_level` and `o_pulse` go high after edge k+1+DEBOUNCE_CYCLES; `o_pulse` low again after edge k+2+DEBOUNCE_CYCLES.
- Press latency = DEBOUNCE_CYCLES+2 edges from raw input change; release latency identical on `o_level`.
- Any `s` glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
- Minimum press-to-press spacing: 2·DEBOUNCE_CYCLES cycles (press accept + release accept).

## Structure
- Shared package/header `debounce_pkg`: FSM state encodings (`ST_STABLE_LOW`, `ST_ARM_HIGH`, `ST_STABLE_HIGH`, `ST_ARM_LOW`, 2 bits) and default `DEBOUNCE_CYCLES` for synthesis vs. simulation.
- Sub-module `debounce_channel` (synchronizer + FSM + counter, one bit); `btn_debouncer` instantiates it `N_BTN` times in a generate loop.
- Top replaces direct `btnL/btnC/btnR` enables with `o_pulse[0..2]`.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4, N_BTN=3.)
- Reset asserted mid-run with `i_btn`=3'b111 → `o_level`=0, `o_pulse`=0 immediately (async); after release and hold, pulses on all channels at edge 5 after release.
- Clean press of bit 0 before edge 0, held 20 cycles → `o_level[0]`=1 and `o_pulse[0]`=1 after edge 5, `o_pulse[0]`=0 after edge 6; single pulse only.
- Bounce: bit 1 toggled 1,0,1,1,0 on consecutive cycles then held 1 → no output during bounce; one pulse 6 edges after last 0→1.
- Release: bit 0 drops after stable high → `o_level[0]`=0 after edge 5 of drop, `o_pulse` stays 0.
- Bits 0 and 2 pressed same cycle, bit 1 pressed 2 cycles later → pulses on 0 and 2 in same cycle, bit 1 two cycles later, each one cycle wide.
- Glitch of 3 cycles high (< DEBOUNCE_CYCLES) on bit 2 → `o_level[2]` and `o_pulse[2]` remain 0.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encodings and the default stability window for synthesis and simulation.
package btn_debouncer_pkg;

  typedef enum logic [1:0] {
    StStableLow  = 2'b00,
    StArmHigh    = 2'b01,
    StStableHigh = 2'b10,
    StArmLow     = 2'b11
  } state_e;

  // 10 ms at 100 MHz on the board; a short window keeps simulations fast.
  localparam int unsigned DebounceCyclesSynth = 1_000_000;
  localparam int unsigned DebounceCyclesSim   = 4;

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the board pins and the debouncer: raw levels in,
// debounced levels and single-cycle press pulses out.
interface btn_debouncer_if #(
  parameter int unsigned N_BTN = 3
) ();

  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_pulse;

  modport master (
    output i_btn,
    input  o_level,
    input  o_pulse
  );

  modport slave (
    input  i_btn,
    output o_level,
    output o_pulse
  );

endinterface

// File: rtl/btn_debouncer_channel.sv
// One button channel: 2-FF synchronizer, stability FSM with counter, and a
// registered level plus a one-cycle pulse on each accepted press.
module btn_debouncer_channel
  import btn_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesSynth,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 pulse_q, pulse_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StStableLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // The first differing sample already counts as one, so acceptance lands on
  // the DEBOUNCE_CYCLES-th consecutive stable sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StStableLow: begin
        if (sync2_q) begin
          state_d = StArmHigh;
          cnt_d   = CntOne;
        end
      end
      StArmHigh: begin
        if (!sync2_q) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableHigh;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHigh: begin
        if (!sync2_q) begin
          state_d = StArmLow;
          cnt_d   = CntOne;
        end
      end
      StArmLow: begin
        if (sync2_q) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableLow;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStableLow;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces N_BTN independent push buttons; o_pulse drives the operand A,
// operand B and opcode load enables so each physical press loads once.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesSynth,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic             CLK100MHZ,
  input logic             reset,
  btn_debouncer_if.slave  btn_bus
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debouncer_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan (
      .clk_i   (CLK100MHZ),
      .rst_i   (reset),
      .btn_i   (btn_bus.i_btn[i]),
      .level_o (btn_bus.o_level[i]),
      .pulse_o (btn_bus.o_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYCLES=4 and three channels;
// edge numbers count rising edges after the input change under test.
module tb_btn_debouncer;

  localparam int unsigned NBtn = 3;
  localparam int unsigned Deb  = 4;

  logic clk;
  logic rst;

  btn_debouncer_if #(.N_BTN(NBtn)) bus ();

  btn_debouncer #(
    .N_BTN           (NBtn),
    .DEBOUNCE_CYCLES (Deb)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .btn_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_num;
  int pulse_cnt  [NBtn];
  int pulse_edge [NBtn];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    edge_num = -1;
    for (int b = 0; b < NBtn; b++) begin
      pulse_cnt[b]  = 0;
      pulse_edge[b] = -1;
    end
  endtask

  // Apply a raw level, take one rising edge and log any pulses seen after it.
  task automatic step(input logic [2:0] btn);
    bus.i_btn = btn;
    @(posedge clk);
    #1;
    edge_num++;
    for (int b = 0; b < NBtn; b++) begin
      if (bus.o_pulse[b]) begin
        pulse_cnt[b]++;
        pulse_edge[b] = edge_num;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.i_btn = 3'b000;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_level", 32'(bus.o_level), 32'd0);
    check_eq("reset_pulse", 32'(bus.o_pulse), 32'd0);
    rst = 1'b0;
    repeat (3) step(3'b000);

    // Clean press on bit 0.
    clear_stats();
    repeat (5) step(3'b001);
    check_eq("press0_level_e4", 32'(bus.o_level[0]), 32'd0);
    step(3'b001);
    check_eq("press0_level_e5", 32'(bus.o_level[0]), 32'd1);
    check_eq("press0_pulse_e5", 32'(bus.o_pulse[0]), 32'd1);
    step(3'b001);
    check_eq("press0_pulse_e6", 32'(bus.o_pulse[0]), 32'd0);
    repeat (13) step(3'b001);
    check_eq("press0_pulse_cnt", 32'(pulse_cnt[0]), 32'd1);
    check_eq("press0_level_hold", 32'(bus.o_level), 32'b001);

    // Release of bit 0.
    clear_stats();
    repeat (5) step(3'b000);
    check_eq("rel0_level_e4", 32'(bus.o_level[0]), 32'd1);
    step(3'b000);
    check_eq("rel0_level_e5", 32'(bus.o_level[0]), 32'd0);
    repeat (4) step(3'b000);
    check_eq("rel0_no_pulse", 32'(pulse_cnt[0]), 32'd0);

    // Bounce on bit 1, last rise before edge 5.
    clear_stats();
    step(3'b010);
    step(3'b000);
    step(3'b010);
    step(3'b010);
    step(3'b000);
    repeat (5) step(3'b010);
    check_eq("bounce1_level_e9", 32'(bus.o_level[1]), 32'd0);
    check_eq("bounce1_quiet_e9", 32'(pulse_cnt[1]), 32'd0);
    repeat (6) step(3'b010);
    check_eq("bounce1_pulse_cnt", 32'(pulse_cnt[1]), 32'd1);
    check_eq("bounce1_pulse_edge", 32'(pulse_edge[1]), 32'd10);
    check_eq("bounce1_level", 32'(bus.o_level), 32'b010);
    repeat (8) step(3'b000);
    check_eq("bounce1_released", 32'(bus.o_level), 32'd0);

    // Bits 0 and 2 together, bit 1 two cycles later.
    clear_stats();
    step(3'b101);
    step(3'b101);
    repeat (14) step(3'b111);
    check_eq("multi_cnt0", 32'(pulse_cnt[0]), 32'd1);
    check_eq("multi_cnt1", 32'(pulse_cnt[1]), 32'd1);
    check_eq("multi_cnt2", 32'(pulse_cnt[2]), 32'd1);
    check_eq("multi_edge0", 32'(pulse_edge[0]), 32'd5);
    check_eq("multi_edge1", 32'(pulse_edge[1]), 32'd7);
    check_eq("multi_edge2", 32'(pulse_edge[2]), 32'd5);
    check_eq("multi_level", 32'(bus.o_level), 32'b111);
    repeat (8) step(3'b000);
    check_eq("multi_released", 32'(bus.o_level), 32'd0);

    // Three-sample glitch on bit 2 must be rejected.
    clear_stats();
    repeat (3) step(3'b100);
    repeat (10) step(3'b000);
    check_eq("glitch2_pulse", 32'(pulse_cnt[2]), 32'd0);
    check_eq("glitch2_level", 32'(bus.o_level[2]), 32'd0);

    // Asynchronous reset with all buttons held high and accepted.
    repeat (8) step(3'b111);
    check_eq("pre_reset_level", 32'(bus.o_level), 32'b111);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_level", 32'(bus.o_level), 32'd0);
    check_eq("async_reset_pulse", 32'(bus.o_pulse), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    repeat (10) step(3'b111);
    for (int b = 0; b < NBtn; b++) begin
      check_eq($sformatf("post_reset_edge%0d", b), 32'(pulse_edge[b]), 32'd5);
      check_eq($sformatf("post_reset_cnt%0d", b), 32'(pulse_cnt[b]), 32'd1);
    end
    check_eq("post_reset_level", 32'(bus.o_level), 32'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
